// File: rtl/note_select_gate_pkg.sv
// Shared definitions for the note selector: FSM encodings and the default debounce length.
package note_select_gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int DEB_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/note_select_gate_key_debounce.sv
// One key: two-flop synchroniser, then a stable value that only follows the synced
// input after DEB_CYCLES consecutive disagreeing cycles.
module key_debounce
  import note_select_gate_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_db
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync   <= '0;
      cnt    <= '0;
      key_db <= 1'b0;
    end else begin
      sync <= {sync[0], key_raw};
      if (sync[1] == key_db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // this cycle is the DEB_CYCLES-th disagreeing one
        key_db <= sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/note_select_gate.sv
// Debounced lowest-index key selects one timer tone; changes only happen while the tone is low.
// Optional VOLUME_PWM_EN adds a free-running duty counter that scales the output by volume.
module note_select_gate
  import note_select_gate_pkg::*;
#(
  parameter int NUM_NOTES  = 8,
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int VOL_BITS   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_NOTES-1:0]         key_raw,
  input  logic [NUM_NOTES-1:0]         tone_in,
  input  logic [VOL_BITS-1:0]          volume,
  output logic                         audio_out,
  output logic [$clog2(NUM_NOTES)-1:0] note_idx,
  output logic                         note_valid,
  output logic [NUM_NOTES-1:0]         keys_db
);

  localparam int IW = $clog2(NUM_NOTES);

  state_t        state, state_nxt;
  logic [IW-1:0] sel, sel_nxt;
  logic [IW-1:0] want;
  logic          none;
  logic          gate_nxt;
  logic          audio_nxt;

  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .reset  (reset),
      .key_raw(key_raw[g]),
      .key_db (keys_db[g])
    );
  end

  always_comb begin
    want = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (keys_db[i]) want = IW'(i);
    end
  end

  assign none = ~|keys_db;

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    gate_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!none) begin
          sel_nxt   = want;
          state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        if (none) begin
          state_nxt = ST_IDLE;
        end else begin
          sel_nxt = want;
          if (!tone_in[want]) state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        gate_nxt = tone_in[sel];
        if (none || (want != sel)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // finish the current high half before letting go of the note
        if (tone_in[sel]) gate_nxt = 1'b1;
        else              state_nxt = none ? ST_IDLE : ST_ARM;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef VOLUME_PWM_EN
  logic [VOL_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + VOL_BITS'(1);
  end

  assign audio_nxt = gate_nxt & (pwm_cnt < volume);
`else
  logic unused_volume;
  assign unused_volume = ^volume;
  assign audio_nxt     = gate_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      sel       <= '0;
      audio_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      audio_out <= audio_nxt;
    end
  end

  assign note_valid = (state == ST_PLAY);
  assign note_idx   = note_valid ? sel : '0;

endmodule

// File: tb/tb_note_select_gate.sv
// Directed bench for note_select_gate (4 notes, 4-cycle debounce) with an audio scoreboard.
module tb_note_select_gate;
  import note_select_gate_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_raw;
  logic [3:0] tone_in;
  logic [3:0] volume;
  logic       audio_out;
  logic [1:0] note_idx;
  logic       note_valid;
  logic [3:0] keys_db;

  int   total = 0;
  int   bad   = 0;
  logic tone_hold = 1'b0;
  logic sb_on = 1'b0;
  int   sb_idx = 0;
  logic sb_q[$];

  note_select_gate #(.NUM_NOTES(4), .DEB_CYCLES(4), .VOL_BITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_raw   (key_raw),
    .tone_in   (tone_in),
    .volume    (volume),
    .audio_out (audio_out),
    .note_idx  (note_idx),
    .note_valid(note_valid),
    .keys_db   (keys_db)
  );

  initial forever #5 clk = ~clk;

  // tone i toggles every 3+i cycles, updated just after each rising edge
  initial begin
    int tcnt[4];
    tone_in = '0;
    for (int i = 0; i < 4; i++) tcnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (tcnt[i] == 2 + i) begin
          tcnt[i] = 0;
          tone_in[i] = ~tone_in[i];
        end else begin
          tcnt[i] = tcnt[i] + 1;
        end
        if (tone_hold) tone_in[i] = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one cycle; audio_out must equal the tone pushed one cycle earlier
  task automatic step();
    @(negedge clk);
    if (sb_on) begin
      if (sb_q.size() > 0) chk("sb_audio", 32'(audio_out), 32'(sb_q.pop_front()));
      sb_q.push_back(tone_in[sb_idx]);
    end
  endtask

  task automatic sb_start(input int idx);
    sb_q.delete();
    sb_idx = idx;
    sb_on  = 1'b1;
  endtask

  task automatic sb_stop();
    sb_on = 1'b0;
    sb_q.delete();
  endtask

  task automatic wait_play(input int idx, input int budget, input string tag);
    int n = 0;
    while (!(note_valid && note_idx == 2'(idx)) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(note_valid), 1);
    chk({tag, "_idx"}, 32'(note_idx), 32'(idx));
  endtask

  // stop at the negedge where the next sampled tone_in[idx] is the first with value 'level'
  task automatic find_edge(input int idx, input logic level, input string tag);
    int   n = 0;
    logic prev = tone_in[idx];
    logic found = 1'b0;
    while (!found && n < 20) begin
      step();
      n++;
      if (prev == !level && tone_in[idx] == level) found = 1'b1;
      prev = tone_in[idx];
    end
    chk(tag, 32'(found), 1);
  endtask

  initial begin
    int n;
    reset = 1'b1; key_raw = '0; volume = '0;

    repeat (3) step();
    chk("rst_audio", 32'(audio_out), 0);
    chk("rst_valid", 32'(note_valid), 0);
    chk("rst_keys", 32'(keys_db), 0);
    chk("rst_idx", 32'(note_idx), 0);
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    reset = 1'b0;
    repeat (2) step();

    // 1: a 3-cycle glitch is rejected, a held key lands after exactly 6 cycles
    key_raw[2] = 1'b1;
    repeat (3) step();
    key_raw[2] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t1_glitch_keys", 32'(keys_db), 0);
      chk("t1_glitch_audio", 32'(audio_out), 0);
    end
    key_raw[2] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t1_hold_keys", 32'(keys_db), (k < 6) ? 32'h0 : 32'h4);
    end

`ifdef VOLUME_PWM_EN
    // 6: volume 0 mutes, volume 8 passes half the cycles of a held-high tone
    wait_play(2, 30, "t6_play");
    n = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (audio_out) n++;
    end
    chk("t6_mute_highs", 32'(n), 0);
    volume = 4'd8;
    tone_hold = 1'b1;
    repeat (3) step();
    n = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (audio_out) n++;
    end
    chk("t6_duty_highs", 32'(n), 16);
    chk("t6_still_play", 32'(note_valid), 1);
`else
    // 2: ARM waits for a low tone, so the first high pulse is full width (5 cycles)
    wait_play(2, 30, "t2_play");
    chk("t2_entry_audio", 32'(audio_out), 0);
    sb_start(2);
    n = 0;
    while (!audio_out && n < 20) begin step(); n++; end
    n = 0;
    while (audio_out && n < 20) begin step(); n++; end
    chk("t2_first_pulse_len", 32'(n), 5);
    repeat (6) step();

    // 3: key 1 beats key 2; key 0 arriving during a high phase drains it first
    sb_stop();
    key_raw[1] = 1'b1;
    wait_play(1, 60, "t3_play1");
    sb_start(1);
    repeat (6) step();
    find_edge(1, 1'b0, "t3_phase");
    key_raw[0] = 1'b1;
    repeat (6) step();
    chk("t3_keys", 32'(keys_db), 32'h7);
    chk("t3_still_idx1", 32'(note_idx), 1);
    step();
    chk("t3_drain_valid", 32'(note_valid), 0);
    chk("t3_drain_audio_a", 32'(audio_out), 1);
    step();
    chk("t3_drain_audio_b", 32'(audio_out), 1);
    step();
    chk("t3_drain_end", 32'(audio_out), 0);
    sb_stop();
    wait_play(0, 20, "t3_play0");
    sb_start(0);
    repeat (8) step();

    // 4: release mid-high: the pulse completes, then silence in IDLE
    find_edge(0, 1'b1, "t4_phase");
    step();
    key_raw = '0;
    repeat (6) step();
    chk("t4_keys", 32'(keys_db), 0);
    chk("t4_valid_before", 32'(note_valid), 1);
    step();
    chk("t4_drain_valid", 32'(note_valid), 0);
    chk("t4_drain_audio_a", 32'(audio_out), 1);
    step();
    chk("t4_drain_audio_b", 32'(audio_out), 1);
    step();
    chk("t4_drain_end", 32'(audio_out), 0);
    sb_stop();
    chk("t4_state", 32'(dut.state), 32'(ST_IDLE));
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (audio_out || note_valid) n++;
    end
    chk("t4_idle_quiet", 32'(n), 0);

    // 5: async reset while playing clears outputs at once; held key returns after 6 cycles
    key_raw[0] = 1'b1;
    wait_play(0, 40, "t5_play");
    n = 0;
    while (!audio_out && n < 20) begin step(); n++; end
    chk("t5_audio_high", 32'(audio_out), 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_audio", 32'(audio_out), 0);
    chk("t5_rst_valid", 32'(note_valid), 0);
    chk("t5_rst_keys", 32'(keys_db), 0);
    chk("t5_rst_state", 32'(dut.state), 32'(ST_IDLE));
    repeat (2) step();
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t5_rekey", 32'(keys_db), (k < 6) ? 32'h0 : 32'h1);
    end
    wait_play(0, 30, "t5_replay");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
